// File: rtl/keypad_scanner_param_if.sv
// Key-code handshake between the keypad scanner (master) and its consumer
// (slave). The scanner presents KeyCode/KeyValid; the consumer answers with
// a one-cycle KeyRead.
interface keypad_scanner_param_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] KeyCode;
    logic              KeyValid;
    logic              KeyRead;

    modport master (
        output KeyCode,
        output KeyValid,
        input  KeyRead
    );

    modport slave (
        input  KeyCode,
        input  KeyValid,
        output KeyRead
    );
endinterface

// File: rtl/keypad_scanner_param.sv
// Parametrised ROWS x COLS matrix keypad scanner.
// Drives one column low at a time, samples the active-low rows into a frame
// buffer, debounces over whole frames, requires a full release before
// re-arming, and hands accepted key codes (col*ROWS + row) to the consumer
// over a valid/read handshake.
// Optional build macro KEYPAD_FIFO_EN: replaces the single holding register
// with a 4-entry code FIFO between acceptance and the outputs.
module keypad_scanner_param #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYC      = 2,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      ScanEn,
    input  logic [ROWS-1:0]           RowIn,
    output logic [COLS-1:0]           ColOut,
    output logic                      MultiKey,
    output logic                      Overrun,
    input  logic                      ClearFlags,
    keypad_scanner_param_if.master    key_if
);

    localparam int NKEYS  = ROWS * COLS;
    localparam int CODE_W = $clog2(NKEYS);
    localparam int CNT_W  = $clog2(NKEYS + 1);
    localparam int COL_W  = $clog2(COLS);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int DEB_W  = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic {ST_SCAN, ST_EVAL} scan_state_t;

    scan_state_t       r_state;
    logic              r_scan_on;      // scanning was enabled last cycle
    logic [COL_W-1:0]  r_col_idx;
    logic [SET_W-1:0]  r_settle;
    logic [COLS-1:0]   r_col_drv;      // one-hot: column currently pulled low
    logic [NKEYS-1:0]  r_frame;        // 0 = key closed, index = col*ROWS+row
    logic [DEB_W-1:0]  r_deb_cnt;      // press streak when armed, release streak otherwise
    logic [CODE_W-1:0] r_cand;
    logic              r_armed;
    logic              r_multi;
    logic              r_overrun;

    logic              w_eval;
    logic [CNT_W-1:0]  w_zero_cnt;
    logic [CODE_W-1:0] w_key_code;
    logic [DEB_W-1:0]  w_deb_inc;
    logic [DEB_W-1:0]  w_deb_nxt;
    logic [CODE_W-1:0] w_cand_nxt;
    logic              w_armed_nxt;
    logic              w_accept;
    logic              w_multi_set;
    logic              w_overrun_set;

    // Inactive columns float so the external pull-ups hold them high.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign ColOut[c] = r_col_drv[c] ? 1'b0 : 1'bz;
    end

    assign MultiKey  = r_multi;
    assign Overrun   = r_overrun;
    assign w_eval    = r_scan_on && ScanEn && (r_state == ST_EVAL);
    assign w_deb_inc = r_deb_cnt + DEB_W'(1);

    // Column sequencer: settle, sample, advance, then one evaluation cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_SCAN;
            r_scan_on <= 1'b0;
            r_col_idx <= '0;
            r_settle  <= '0;
            r_col_drv <= '0;
            r_frame   <= '1;
        end else begin
            // NOTE: every clocked register uses non-blocking assignment so all
            // of them update from the same pre-edge values.
            r_scan_on <= ScanEn;
            if (!ScanEn) begin
                // Pause: float the columns and throw away the partial frame.
                r_state   <= ST_SCAN;
                r_col_idx <= '0;
                r_settle  <= '0;
                r_col_drv <= '0;
                r_frame   <= '1;
            end else if (!r_scan_on) begin
                // First enabled cycle: start driving column 0.
                r_col_drv <= COLS'(1);
            end else begin
                case (r_state)
                    ST_SCAN: begin
                        if (r_settle == SET_W'(SETTLE_CYC)) begin
                            r_frame[r_col_idx*ROWS +: ROWS] <= RowIn;
                            r_settle <= '0;
                            if (r_col_idx == COL_W'(COLS - 1)) begin
                                r_state   <= ST_EVAL;
                                r_col_idx <= '0;
                                r_col_drv <= '0;
                            end else begin
                                r_col_idx <= r_col_idx + COL_W'(1);
                                r_col_drv <= r_col_drv << 1;
                            end
                        end else begin
                            r_settle <= r_settle + SET_W'(1);
                        end
                    end
                    ST_EVAL: begin
                        r_state   <= ST_SCAN;
                        r_col_drv <= COLS'(1);
                    end
                    default: r_state <= ST_SCAN;
                endcase
            end
        end
    end

    // Count closed keys in the frame and remember the code of the last one.
    always_comb begin
        // NOTE: every variable gets a default before any condition, so no
        // path leaves it unassigned and no latch is inferred.
        w_zero_cnt = '0;
        w_key_code = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (!r_frame[i]) begin
                w_zero_cnt = w_zero_cnt + CNT_W'(1);
                w_key_code = CODE_W'(i);
            end
        end
    end

    // Frame-level debounce: press streak, release streak, multi-key detect.
    always_comb begin
        logic [DEB_W-1:0] v_streak;
        v_streak    = '0;
        w_deb_nxt   = r_deb_cnt;
        w_cand_nxt  = r_cand;
        w_armed_nxt = r_armed;
        w_accept    = 1'b0;
        w_multi_set = 1'b0;
        if (w_eval) begin
            if (w_zero_cnt == '0) begin
                if (!r_armed) begin
                    if (w_deb_inc == DEB_W'(DEBOUNCE_FRAMES)) begin
                        w_armed_nxt = 1'b1;
                        w_deb_nxt   = '0;
                    end else begin
                        w_deb_nxt = w_deb_inc;
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end else if (w_zero_cnt == CNT_W'(1)) begin
                if (r_armed) begin
                    v_streak   = (w_key_code == r_cand) ? w_deb_inc : DEB_W'(1);
                    w_cand_nxt = w_key_code;
                    if (v_streak == DEB_W'(DEBOUNCE_FRAMES)) begin
                        w_accept    = 1'b1;
                        w_armed_nxt = 1'b0;
                        w_deb_nxt   = '0;
                    end else begin
                        w_deb_nxt = v_streak;
                    end
                end else begin
                    // Still held (or another key) while disarmed: restart release.
                    w_deb_nxt = '0;
                end
            end else begin
                w_deb_nxt   = '0;
                w_multi_set = r_armed;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_deb_cnt <= '0;
            r_cand    <= '0;
            r_armed   <= 1'b1;
        end else begin
            r_deb_cnt <= w_deb_nxt;
            r_cand    <= w_cand_nxt;
            r_armed   <= w_armed_nxt;
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic [CODE_W-1:0] r_fifo [4];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign w_pop         = key_if.KeyRead && (r_count != 3'd0);
    assign w_push        = w_accept && ((r_count != 3'd4) || w_pop);
    assign w_overrun_set = w_accept && !w_push;
    assign key_if.KeyCode  = r_fifo[r_rd_ptr];
    assign key_if.KeyValid = (r_count != 3'd0);

    // Code FIFO: push accepted keys, pop on consumer read.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            // NOTE: the four entries are reset because the head is visible on
            // KeyCode and must read 0 out of reset.
            for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_key_code;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;

    assign w_overrun_set   = w_accept && r_key_valid && !key_if.KeyRead;
    assign key_if.KeyCode  = r_key_code;
    assign key_if.KeyValid = r_key_valid;

    // Single holding register: a read in the acceptance cycle frees the slot.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else if (w_accept && (!r_key_valid || key_if.KeyRead)) begin
            r_key_code  <= w_key_code;
            r_key_valid <= 1'b1;
        end else if (r_key_valid && key_if.KeyRead) begin
            r_key_valid <= 1'b0;
        end
    end
`endif

    // Sticky flags: a set event in the clearing cycle wins.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_multi   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_multi   <= w_multi_set   || (r_multi   && !ClearFlags);
            r_overrun <= w_overrun_set || (r_overrun && !ClearFlags);
        end
    end

endmodule

// File: doc/keypad_scanner_param.md
Name: keypad_scanner_param

Overview:
Parametrised successor of the team's 4x4 matrix keypad scanner, scaling to ROWS x COLS matrices.
- Drives one column low at a time and samples the active-low rows.
- Debounces over whole scan frames and requires release before re-arming.
- Presents a binary key code through a valid/read handshake.
- Sits between the board keypad pins and the calculator input/decoder logic; scanning continues while a code is pending.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column outputs (2..8)
SETTLE_CYC, 2, settle cycles per column before sampling (>=1)
DEBOUNCE_FRAMES, 4, consecutive identical frames required to accept a press or confirm a release (2..15)
CODE_W, $clog2(ROWS*COLS), key code width (derived, not overridden)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
ScanEn  in  1  scan enable; low pauses scanning
RowIn  in  ROWS  keypad rows, active-low, externally pulled up
ColOut  out  COLS  keypad columns: 0 on active column, Z otherwise
KeyCode  out  CODE_W  accepted key code = col_idx*ROWS + row_idx
KeyValid  out  1  KeyCode holds an unread key
KeyRead  in  1  consumer acknowledge, sampled when KeyValid=1
MultiKey  out  1  sticky: frame with >1 key seen during debounce
Overrun  out  1  sticky: key accepted while KeyValid=1 and no free slot
ClearFlags  in  1  one-cycle pulse clears MultiKey and Overrun

Behaviour:
Reset (Reset=0):
- Outputs: ColOut all Z; KeyCode=0; KeyValid=0; MultiKey=0; Overrun=0.
- Internal: state=SCAN, col_idx=0, settle counter=0, debounce counter=0, armed=1, frame buffer all 1s.
- Reset mid-frame or mid-handshake discards everything, including a pending key.

Scan timing:
- Column c is driven 0 for SETTLE_CYC+1 cycles.
- RowIn is sampled into frame[c*ROWS +: ROWS] on the last of those cycles, then the next column is driven.
- After column COLS-1, one EVAL cycle follows. Frame period = COLS*(SETTLE_CYC+1)+1 cycles.
- During EVAL: ColOut is all Z; col_idx returns to 0.

ScanEn:
- ScanEn=0: ColOut goes all Z the next cycle; the partial frame is discarded; the debounce counter and armed are retained.
- ScanEn returning to 1 restarts at column 0 with a fresh settle count.

EVAL (count = number of 0 bits in frame):
- count==0:
  - armed=0: release counter increments; on reaching DEBOUNCE_FRAMES, armed=1 and counter=0.
  - armed=1: press counter=0.
- count==1 and armed=1:
  - If code equals the candidate code, the press counter increments; otherwise candidate=code and counter=1.
  - When the counter reaches DEBOUNCE_FRAMES: key accepted, armed=0, counter=0.
- count==1 and armed=0: release counter=0, so the key must be fully released before re-arming.
- count>1: all counters=0; if armed=1, set MultiKey; no acceptance.

Handshake:
- Accepted key: KeyCode loaded and KeyValid=1 on the cycle after EVAL.
- KeyRead=1 with KeyValid=1: KeyValid=0 next cycle; KeyCode holds its value.
- KeyRead while KeyValid=0 is ignored.
- Acceptance in the same cycle as KeyRead: the new code loads and KeyValid stays 1; not an overrun.
- Acceptance while KeyValid=1 without KeyRead: the new key is dropped, Overrun=1, and KeyCode is unchanged.

Sticky flags:
- ClearFlags clears MultiKey and Overrun next cycle.
- A set event in the same cycle as ClearFlags wins, so the flag stays 1.

Optional Feature:
KEYPAD_FIFO_EN
- Defined: a 4-entry code FIFO sits between acceptance and the outputs.
  - KeyCode/KeyValid show the FIFO head; KeyRead pops.
  - Overrun is set only when an acceptance finds the FIFO full (4 entries, no pop that cycle); that key is dropped.
  - Simultaneous push and pop on a full FIFO succeeds.
  - FIFO cleared by reset.
- Undefined: a single holding register, with behaviour as described above.

Test Plan:
All scenarios use ROWS=COLS=4, SETTLE_CYC=2, DEBOUNCE_FRAMES=3, frame=13 cycles.
- Row 2 held low only while column 1 is driven, from reset -> KeyValid=1 after the 3rd frame's EVAL (cycle 40); KeyCode=6; KeyRead pulse -> KeyValid=0 next cycle.
- Key 6 held for 10 frames after acceptance -> exactly one acceptance; release for 3 frames, then press key 9 for 3 frames -> KeyCode=9.
- Keys 0 and 5 pressed together for 5 frames -> MultiKey=1, KeyValid stays 0; ClearFlags -> MultiKey=0.
- Key 3 accepted, no KeyRead, release then press key 12 for 3 frames -> Overrun=1, KeyCode stays 3. With KEYPAD_FIFO_EN: no Overrun, reads return 3 then 12.
- Bounce: key 7 toggled every frame for 6 frames -> no acceptance, counters stay below 3.
- ScanEn dropped mid-frame in column 2 -> ColOut all Z next cycle; restart at column 0. Reset asserted with KeyValid=1 -> KeyValid=0 immediately (asynchronous).
